// File: rtl/rom_mmap_pkg.sv
// Shared types and constants for the memory-mapped microcode store.
// Contents: region enum, FSM state enum, default region bases and the
// constant-table generator con_value().
package rom_pkg;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_CSR,
        RGN_GPR,
        RGN_TMP,
        RGN_CON,
        RGN_PRC
    } rom_region_e;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } rom_state_e;

    localparam logic [31:0] DEF_CSR_BASE = 32'hffff8000;
    localparam logic [31:0] DEF_GPR_BASE = 32'hffffc000;
    localparam logic [31:0] DEF_TMP_BASE = 32'hffffc080;
    localparam logic [31:0] DEF_CON_BASE = 32'hffffc100;
    localparam logic [31:0] DEF_PRC_BASE = 32'hffffe000;

    // Widest word the constant generator can produce; callers cast down.
    localparam int CON_MAX_W = 256;

    // Entry idx < width is a one-hot (1 << idx); entry width+i is a mask of
    // the i low bits, i.e. (1 << i) - 1.
    function automatic logic [CON_MAX_W-1:0] con_value(input int unsigned idx,
                                                       input int unsigned width);
        logic [CON_MAX_W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < CON_MAX_W; j++) begin
            if (idx < width) v[j] = (j == idx);
            else             v[j] = (j < idx - width);
        end
        return v;
    endfunction

endpackage

// File: rtl/rom_mmap_if.sv
// Request/response port of rom_mmap.
//   req_valid/req_ready : request handshake
//   req_we, req_be      : write flag and byte enables
//   req_addr, req_wdata : byte address and write data
//   rsp_valid           : one-cycle response pulse per accepted request
//   rsp_rdata, rsp_err  : read data (0 on writes/errors) and error flag
interface rom_mmap_if #(
    parameter int DATA_W = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rom_mmap_decode.sv
// Address decoder for rom_mmap: maps a byte address to a region and the word
// index inside each region, and flags misaligned addresses.
//   i_addr        : byte address
//   o_region      : matching region, RGN_NONE if unmapped
//   o_misaligned  : address not word aligned
//   o_*_idx       : word index within each region (valid when o_region matches)
module rom_decode
    import rom_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          CSR_DEPTH = 4096,
    parameter int          GPR_NUM   = 32,
    parameter int          TMP_NUM   = 32,
    parameter int          PRC_DEPTH = 2048,
    parameter logic [31:0] CSR_BASE  = DEF_CSR_BASE,
    parameter logic [31:0] GPR_BASE  = DEF_GPR_BASE,
    parameter logic [31:0] TMP_BASE  = DEF_TMP_BASE,
    parameter logic [31:0] CON_BASE  = DEF_CON_BASE,
    parameter logic [31:0] PRC_BASE  = DEF_PRC_BASE
) (
    input  logic [31:0]                    i_addr,
    output rom_region_e                    o_region,
    output logic                           o_misaligned,
    output logic [$clog2(CSR_DEPTH)-1:0]   o_csr_idx,
    output logic [$clog2(GPR_NUM)-1:0]     o_gpr_idx,
    output logic [$clog2(TMP_NUM)-1:0]     o_tmp_idx,
    output logic [$clog2(2*DATA_W)-1:0]    o_con_idx,
    output logic [$clog2(PRC_DEPTH)-1:0]   o_prc_idx
);
    localparam int CSR_AW = $clog2(CSR_DEPTH);
    localparam int GPR_AW = $clog2(GPR_NUM);
    localparam int TMP_AW = $clog2(TMP_NUM);
    localparam int CON_AW = $clog2(2*DATA_W);
    localparam int PRC_AW = $clog2(PRC_DEPTH);

    // Unsigned offset from each base: addresses below the base wrap to huge
    // values, so a single "offset < size" test covers both range ends.
    logic [31:0] w_off_csr, w_off_gpr, w_off_tmp, w_off_con, w_off_prc;

    assign w_off_csr = i_addr - CSR_BASE;
    assign w_off_gpr = i_addr - GPR_BASE;
    assign w_off_tmp = i_addr - TMP_BASE;
    assign w_off_con = i_addr - CON_BASE;
    assign w_off_prc = i_addr - PRC_BASE;

    always_comb begin
        o_region = RGN_NONE;
        if      (w_off_csr < 32'(4*CSR_DEPTH)) o_region = RGN_CSR;
        else if (w_off_gpr < 32'(4*GPR_NUM))   o_region = RGN_GPR;
        else if (w_off_tmp < 32'(4*TMP_NUM))   o_region = RGN_TMP;
        else if (w_off_con < 32'(8*DATA_W))    o_region = RGN_CON;
        else if (w_off_prc < 32'(4*PRC_DEPTH)) o_region = RGN_PRC;
    end

    assign o_misaligned = |i_addr[1:0];
    assign o_csr_idx    = w_off_csr[CSR_AW+1:2];
    assign o_gpr_idx    = w_off_gpr[GPR_AW+1:2];
    assign o_tmp_idx    = w_off_tmp[TMP_AW+1:2];
    assign o_con_idx    = w_off_con[CON_AW+1:2];
    assign o_prc_idx    = w_off_prc[PRC_AW+1:2];
endmodule

// File: rtl/rom_mmap.sv
// Memory-mapped microcode store: CSR shadow, GPR file, temporaries, a
// read-only constant table and a lockable procedure store behind one
// request/response port, plus a clear engine that zeroes GPR and TMP.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   bus        : request/response port (slave side)
//   clr_start  : start clearing GPR then TMP
//   clr_busy   : clear in progress (requests stalled)
//   prc_lock   : procedure region read-only when 1
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | accepting one request per cycle
// S_CLEAR  | zeroing one GPR/TMP word per cycle, requests stalled
module rom_mmap
    import rom_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          CSR_DEPTH = 4096,
    parameter int          GPR_NUM   = 32,
    parameter int          TMP_NUM   = 32,
    parameter int          PRC_DEPTH = 2048,
    parameter logic [31:0] CSR_BASE  = DEF_CSR_BASE,
    parameter logic [31:0] GPR_BASE  = DEF_GPR_BASE,
    parameter logic [31:0] TMP_BASE  = DEF_TMP_BASE,
    parameter logic [31:0] CON_BASE  = DEF_CON_BASE,
    parameter logic [31:0] PRC_BASE  = DEF_PRC_BASE
) (
    input  logic         clk,
    input  logic         rst,
    rom_mmap_if.slave    bus,
    input  logic         clr_start,
    output logic         clr_busy,
    input  logic         prc_lock
);
    localparam int CSR_AW = $clog2(CSR_DEPTH);
    localparam int GPR_AW = $clog2(GPR_NUM);
    localparam int TMP_AW = $clog2(TMP_NUM);
    localparam int CON_AW = $clog2(2*DATA_W);
    localparam int PRC_AW = $clog2(PRC_DEPTH);
    localparam int CLR_W  = $clog2(GPR_NUM + TMP_NUM);
    localparam int NBYTE  = DATA_W / 8;

    localparam logic [0:0]       S_IDLE   = ST_IDLE;
    localparam logic [0:0]       S_CLEAR  = ST_CLEAR;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(GPR_NUM + TMP_NUM - 1);
    localparam logic [CLR_W-1:0] CLR_GPRN = CLR_W'(GPR_NUM);

    rom_region_e         w_region;
    logic                w_misaligned;
    logic [CSR_AW-1:0]   w_csr_idx;
    logic [GPR_AW-1:0]   w_gpr_idx;
    logic [TMP_AW-1:0]   w_tmp_idx;
    logic [CON_AW-1:0]   w_con_idx;
    logic [PRC_AW-1:0]   w_prc_idx;

    rom_decode #(
        .DATA_W(DATA_W), .CSR_DEPTH(CSR_DEPTH), .GPR_NUM(GPR_NUM),
        .TMP_NUM(TMP_NUM), .PRC_DEPTH(PRC_DEPTH),
        .CSR_BASE(CSR_BASE), .GPR_BASE(GPR_BASE), .TMP_BASE(TMP_BASE),
        .CON_BASE(CON_BASE), .PRC_BASE(PRC_BASE)
    ) u_decode (
        .i_addr       (bus.req_addr),
        .o_region     (w_region),
        .o_misaligned (w_misaligned),
        .o_csr_idx    (w_csr_idx),
        .o_gpr_idx    (w_gpr_idx),
        .o_tmp_idx    (w_tmp_idx),
        .o_con_idx    (w_con_idx),
        .o_prc_idx    (w_prc_idx)
    );

    logic [0:0]        r_state;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic              w_accept, w_err, w_wr, w_rd;
    logic              w_clr_gpr, w_clr_tmp;
    logic [TMP_AW-1:0] w_tmp_clr_idx;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_err    = (w_region == RGN_NONE) || w_misaligned ||
                      (bus.req_we && ((w_region == RGN_CON) ||
                                      ((w_region == RGN_PRC) && prc_lock)));
    assign w_wr     = w_accept &&  bus.req_we && !w_err;
    assign w_rd     = w_accept && !bus.req_we && !w_err;

    assign w_clr_gpr     = (r_state == S_CLEAR) && (r_clr_cnt <  CLR_GPRN);
    assign w_clr_tmp     = (r_state == S_CLEAR) && (r_clr_cnt >= CLR_GPRN);
    assign w_tmp_clr_idx = TMP_AW'(r_clr_cnt - CLR_GPRN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state   <= S_IDLE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage arrays: not reset, synchronous read into a per-array register.
    logic [DATA_W-1:0] r_csr_mem [CSR_DEPTH];
    logic [DATA_W-1:0] r_gpr_mem [GPR_NUM];
    logic [DATA_W-1:0] r_tmp_mem [TMP_NUM];
    logic [DATA_W-1:0] r_prc_mem [PRC_DEPTH];
    logic [DATA_W-1:0] r_csr_q, r_gpr_q, r_tmp_q, r_con_q, r_prc_q;

    always_ff @(posedge clk) begin
        if (w_wr && (w_region == RGN_CSR))
            for (int b = 0; b < NBYTE; b++)
                if (bus.req_be[b]) r_csr_mem[w_csr_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        if (w_rd && (w_region == RGN_CSR)) r_csr_q <= r_csr_mem[w_csr_idx];
    end

    // GPR 0 is hard-wired to zero: writes are dropped, reads return 0.
    always_ff @(posedge clk) begin
        if (w_clr_gpr)
            r_gpr_mem[r_clr_cnt[GPR_AW-1:0]] <= '0;
        else if (w_wr && (w_region == RGN_GPR) && (w_gpr_idx != '0))
            for (int b = 0; b < NBYTE; b++)
                if (bus.req_be[b]) r_gpr_mem[w_gpr_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        if (w_rd && (w_region == RGN_GPR))
            r_gpr_q <= (w_gpr_idx == '0) ? '0 : r_gpr_mem[w_gpr_idx];
    end

    always_ff @(posedge clk) begin
        if (w_clr_tmp)
            r_tmp_mem[w_tmp_clr_idx] <= '0;
        else if (w_wr && (w_region == RGN_TMP))
            for (int b = 0; b < NBYTE; b++)
                if (bus.req_be[b]) r_tmp_mem[w_tmp_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        if (w_rd && (w_region == RGN_TMP)) r_tmp_q <= r_tmp_mem[w_tmp_idx];
    end

    always_ff @(posedge clk) begin
        if (w_wr && (w_region == RGN_PRC))
            for (int b = 0; b < NBYTE; b++)
                if (bus.req_be[b]) r_prc_mem[w_prc_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        if (w_rd && (w_region == RGN_PRC)) r_prc_q <= r_prc_mem[w_prc_idx];
    end

    always_ff @(posedge clk) begin
        if (w_rd && (w_region == RGN_CON))
            r_con_q <= DATA_W'(con_value(32'(w_con_idx), 32'(DATA_W)));
    end

    logic              r_rsp_valid, r_rsp_err, r_rsp_rd;
    rom_region_e       r_rsp_region;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rd     <= 1'b0;
            r_rsp_region <= RGN_NONE;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            r_rsp_rd    <= w_rd;
            if (w_rd) r_rsp_region <= w_region;
        end
    end

    // Only successful reads return data; writes, errors and idle cycles give 0.
    always_comb begin
        w_rdata = '0;
        if (r_rsp_rd) begin
            case (r_rsp_region)
                RGN_CSR: w_rdata = r_csr_q;
                RGN_GPR: w_rdata = r_gpr_q;
                RGN_TMP: w_rdata = r_tmp_q;
                RGN_CON: w_rdata = r_con_q;
                RGN_PRC: w_rdata = r_prc_q;
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = w_rdata;
    assign clr_busy      = (r_state == S_CLEAR);
endmodule

// File: tb/tb_rom_mmap.sv
module tb_rom_mmap;
    localparam longint unsigned CSR_B = 64'hffff8000;
    localparam longint unsigned GPR_B = 64'hffffc000;
    localparam longint unsigned TMP_B = 64'hffffc080;
    localparam longint unsigned CON_B = 64'hffffc100;
    localparam longint unsigned PRC_B = 64'hffffe000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_start = 1'b0;
    logic prc_lock = 1'b0;
    logic clr_busy;

    always #5 clk = ~clk;

    rom_mmap_if #(.DATA_W(32)) bus ();

    rom_mmap u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .prc_lock  (prc_lock)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [logic [31:0]];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ad(input longint unsigned base, input int unsigned w);
        return 32'(base + 4 * w);
    endfunction

    // Region: 0 none, 1 csr, 2 gpr, 3 tmp, 4 con, 5 prc
    function automatic int region_of(input logic [31:0] a, output int unsigned idx);
        longint unsigned la;
        la  = a;
        idx = 0;
        if (la >= CSR_B && la < CSR_B + 4*4096) begin idx = int'((la - CSR_B) / 4); return 1; end
        if (la >= GPR_B && la < GPR_B + 4*32)   begin idx = int'((la - GPR_B) / 4); return 2; end
        if (la >= TMP_B && la < TMP_B + 4*32)   begin idx = int'((la - TMP_B) / 4); return 3; end
        if (la >= CON_B && la < CON_B + 4*64)   begin idx = int'((la - CON_B) / 4); return 4; end
        if (la >= PRC_B && la < PRC_B + 4*2048) begin idx = int'((la - PRC_B) / 4); return 5; end
        return 0;
    endfunction

    // Present a request this cycle and record its expected response.
    task automatic drive(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          r;
        int unsigned idx;
        logic [31:0] cur;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        r       = region_of(a, idx);
        e.err   = (r == 0) || (a[1:0] != 2'b00) || (we && (r == 4 || (r == 5 && prc_lock)));
        e.data  = 32'h0;
        e.chk   = 1'b1;
        e.stamp = cyc + 1;
        if (!e.err && we && !(r == 2 && idx == 0)) begin
            if (mdl.exists(a) || be == 4'hf) begin
                cur = mdl.exists(a) ? mdl[a] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
                mdl[a] = cur;
            end
        end else if (!e.err && !we) begin
            if (r == 4)
                e.data = (idx < 32) ? 32'(64'd1 << idx) : 32'((64'd1 << (idx - 32)) - 64'd1);
            else if (r == 2 && idx == 0)
                e.data = 32'h0;
            else if (mdl.exists(a))
                e.data = mdl[a];
            else
                e.chk = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic req(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        drive(we, be, a, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned w;
        case ($urandom_range(0, 9))
            0: begin w = $urandom_range(0, 16); if (w == 16) w = 4095; return ad(CSR_B, w); end
            1, 2, 8: return ad(GPR_B, $urandom_range(0, 31));
            3, 9: return ad(TMP_B, $urandom_range(0, 31));
            4: return ad(CON_B, $urandom_range(0, 63));
            5: begin w = $urandom_range(0, 16); if (w == 16) w = 2047; return ad(PRC_B, w); end
            6: case ($urandom_range(0, 4))
                   0: return 32'h0000_0000;
                   1: return 32'hffff_7ffc;
                   2: return 32'hffff_c200;
                   3: return 32'hffff_dffc;
                   default: return $urandom & 32'h7fff_fffc;
               endcase
            default: return ad(GPR_B, $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
        endcase
    endfunction

    // Scoreboard monitor: compares each response against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.stamp));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    if (e.chk) chk("rsp_rdata", bus.rsp_rdata, e.data);
                end
            end else if (sb.size() != 0 && sb[0].stamp < cyc) begin
                chk("missing_rsp", 32'(bus.rsp_valid), 32'h1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 4'h0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        rst = 1'b1;

        // Give every word touched later a known value.
        for (int w = 0; w < 32; w++) req(1'b1, 4'hf, ad(GPR_B, w), $urandom);
        for (int w = 0; w < 32; w++) req(1'b1, 4'hf, ad(TMP_B, w), $urandom);
        for (int w = 0; w < 16; w++) req(1'b1, 4'hf, ad(CSR_B, w), $urandom);
        for (int w = 0; w < 16; w++) req(1'b1, 4'hf, ad(PRC_B, w), $urandom);
        req(1'b1, 4'hf, ad(CSR_B, 4095), $urandom);
        req(1'b1, 4'hf, ad(PRC_B, 2047), $urandom);
        idle(2);

        // Directed cases.
        req(1'b0, 4'h0, 32'(CON_B + 64'h04), 32'h0);
        req(1'b0, 4'h0, 32'(CON_B + 64'h84), 32'h0);
        req(1'b1, 4'hf, 32'(GPR_B + 64'h08), 32'h0);
        req(1'b1, 4'b0101, 32'(GPR_B + 64'h08), 32'hdeadbeef);
        req(1'b0, 4'h0, 32'(GPR_B + 64'h08), 32'h0);
        req(1'b1, 4'hf, 32'(GPR_B), 32'h12345678);
        req(1'b0, 4'h0, 32'(GPR_B), 32'h0);
        @(negedge clk); prc_lock = 1'b1; drive(1'b1, 4'hf, 32'(PRC_B), 32'hcafef00d);
        req(1'b0, 4'h0, 32'(PRC_B), 32'h0);
        @(negedge clk); prc_lock = 1'b0; drive(1'b1, 4'hf, 32'(PRC_B), 32'hcafef00d);
        req(1'b0, 4'h0, 32'(PRC_B), 32'h0);
        req(1'b0, 4'h0, 32'h0000_0000, 32'h0);
        req(1'b0, 4'h0, 32'(GPR_B + 64'h2), 32'h0);
        req(1'b1, 4'hf, 32'(CON_B), 32'h5555_5555);
        req(1'b0, 4'h0, 32'(CON_B), 32'h0);
        req(1'b1, 4'h0, ad(TMP_B, 3), 32'hffff_ffff);
        req(1'b0, 4'h0, ad(TMP_B, 3), 32'h0);
        req(1'b1, 4'hf, ad(TMP_B, 4), 32'ha5a5_0f0f);
        req(1'b0, 4'h0, ad(TMP_B, 4), 32'h0);
        req(1'b0, 4'h0, ad(CSR_B, 4095), 32'h0);
        req(1'b0, 4'h0, ad(PRC_B, 2047), 32'h0);
        req(1'b0, 4'h0, ad(CON_B, 63), 32'h0);
        req(1'b0, 4'h0, 32'hffff_c200, 32'h0);
        req(1'b0, 4'h0, 32'hffff_7ffc, 32'h0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            @(negedge clk);
            prc_lock = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);
        end
        idle(1);
        prc_lock = 1'b0;
        idle(2);

        // Clear with a request accepted in the start cycle and a stray start mid-clear.
        @(negedge clk);
        clr_start = 1'b1;
        drive(1'b1, 4'hf, ad(TMP_B, 20), 32'h600d_f00d);
        @(negedge clk);
        clr_start     = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("clr_busy_high", 32'(clr_busy), 32'h1);
            chk("clr_ready_low", 32'(bus.req_ready), 32'h0);
            clr_start = (i == 20);
            @(negedge clk);
        end
        clr_start = 1'b0;
        chk("clr_busy_done", 32'(clr_busy), 32'h0);
        chk("clr_ready_done", 32'(bus.req_ready), 32'h1);
        for (int w = 0; w < 32; w++) begin
            mdl[ad(GPR_B, w)] = 32'h0;
            mdl[ad(TMP_B, w)] = 32'h0;
        end
        for (int w = 0; w < 32; w++) req(1'b0, 4'h0, ad(GPR_B, w), 32'h0);
        for (int w = 0; w < 32; w++) req(1'b0, 4'h0, ad(TMP_B, w), 32'h0);
        for (int w = 0; w < 16; w++) req(1'b0, 4'h0, ad(CSR_B, w), 32'h0);

        // Reset ten cycles into a clear leaves a partial clear behind.
        for (int w = 1; w < 32; w++) req(1'b1, 4'hf, ad(GPR_B, w), $urandom | 32'h1);
        idle(4);
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_mid_clr_ready", 32'(bus.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int w = 0; w < 10; w++) mdl[ad(GPR_B, w)] = 32'h0;
        for (int w = 0; w < 32; w++) req(1'b0, 4'h0, ad(GPR_B, w), 32'h0);
        idle(4);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
